// File: rtl/div_pkg.sv
// Shared types and constants for the shared divider sequencer.
// State encoding, default width and the zero-divisor quotient fill.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DIV_W = 8;

  // Divide-by-zero returns an all-ones quotient of any width.
  localparam logic DIV_ZQ_FILL = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first request after index i_last wins.
// Ports: i_req, i_last, i_en -> o_gnt (one-hot), o_idx (encoded).
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_last,
  input  logic            i_en,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx
);

  logic w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (int'(i_last) + k) % NREQ;
      if (i_en && !w_found && i_req[c]) begin
        w_found  = 1'b1;
        o_gnt[c] = 1'b1;
        o_idx    = IDW'(c);
      end
    end
  end

endmodule

// File: rtl/div_share_sequencer.sv
// Shared repeated-subtraction divider with round-robin request arbitration.
// Ports: req_* request bundle in, resp_* result bundle out, busy status.
module div_share_sequencer
  import div_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = DIV_W,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [NREQ*W-1:0] req_dividend,
  input  logic [NREQ*W-1:0] req_divisor,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [IDW-1:0]  resp_id,
  output logic [W-1:0]    resp_quot,
  output logic [W-1:0]    resp_rem,
  output logic            resp_err,
  output logic            busy
);

  state_t r_state;
  state_t w_next;

  logic [W-1:0]   r_rem;
  logic [W-1:0]   r_quot;
  logic [W-1:0]   r_div;
  logic [IDW-1:0] r_id;
  logic [IDW-1:0] r_last;
  logic           r_err;

  logic [NREQ-1:0] w_gnt;
  logic [IDW-1:0]  w_idx;
  logic            w_any;
  logic [W-1:0]    w_dvd;
  logic [W-1:0]    w_dvs;

  // Grants only in IDLE and never while reset is asserted.
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .i_req  (req_valid),
    .i_last (r_last),
    .i_en   (r_state == IDLE && !rst),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx)
  );

  assign w_any = |w_gnt;

  // One-hot grant selects the winner's operands.
  always_comb begin
    w_dvd = '0;
    w_dvs = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_dvd = w_dvd | req_dividend[i*W +: W];
        w_dvs = w_dvs | req_divisor[i*W +: W];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_any) w_next = (w_dvs == '0) ? DONE : CMP;
      CMP:  w_next = (r_rem >= r_div) ? SUB : DONE;
      SUB:  w_next = CMP;
      DONE: if (resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_quot  <= '0;
      r_div   <= '0;
      r_id    <= '0;
      r_err   <= 1'b0;
      r_last  <= IDW'(NREQ - 1);
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_last <= w_idx;
            r_id   <= w_idx;
            r_div  <= w_dvs;
            r_rem  <= w_dvd;
            if (w_dvs == '0) begin
              r_quot <= {W{DIV_ZQ_FILL}};
              r_err  <= 1'b1;
            end else begin
              r_quot <= '0;
              r_err  <= 1'b0;
            end
          end
        end
        SUB: begin
          r_rem  <= r_rem - r_div;
          r_quot <= r_quot + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = w_gnt;
  assign resp_valid = (r_state == DONE);
  assign busy       = (r_state != IDLE);
  assign resp_id    = r_id;
  assign resp_quot  = r_quot;
  assign resp_rem   = r_rem;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_div_share_sequencer.sv
// Directed bench for div_share_sequencer (NREQ=2, W=8).
// Hand-computed quotients, remainders, ids, grants and latencies.
module tb_div_share_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_dividend;
  logic [15:0] req_divisor;
  logic        resp_valid;
  logic        resp_ready;
  logic [0:0]  resp_id;
  logic [7:0]  resp_quot;
  logic [7:0]  resp_rem;
  logic        resp_err;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  div_share_sequencer #(.NREQ(2), .W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_quot    (resp_quot),
    .resp_rem     (resp_rem),
    .resp_err     (resp_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic put(input int i, input logic [7:0] dvd,
                     input logic [7:0] dvs);
    req_valid[i] = 1'b1;
    req_dividend[i*8 +: 8] = dvd;
    req_divisor[i*8 +: 8]  = dvs;
  endtask

  // Waits for a grant, counts edges from the accept edge to resp_valid,
  // checks the result, then completes the response handshake.
  task automatic serve(input string tag, input logic [1:0] eg,
                       input logic drop, input logic [0:0] eid,
                       input logic [7:0] eq, input logic [7:0] er,
                       input logic ee, input int elat);
    int t;
    int lat;
    logic [1:0] g;
    #1;
    t = 0;
    while (req_ready == 2'b00 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    g = req_ready;
    chk({tag, ".gnt"}, g, eg);
    lat = 0;
    do begin
      @(posedge clk); #1;
      if (lat == 0 && drop) req_valid = req_valid & ~g;
      lat++;
    end while (!resp_valid && lat < 600);
    chk({tag, ".lat"}, lat, elat);
    chk({tag, ".id"}, resp_id, eid);
    chk({tag, ".q"}, resp_quot, eq);
    chk({tag, ".r"}, resp_rem, er);
    chk({tag, ".err"}, resp_err, ee);
    chk({tag, ".rdy0"}, req_ready, 0);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, ".vld0"}, resp_valid, 0);
    chk({tag, ".idle"}, busy, 0);
  endtask

  initial begin
    int t;
    int ghost;
    rst          = 1'b1;
    req_valid    = '0;
    req_dividend = '0;
    req_divisor  = '0;
    resp_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.vld", resp_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.rdy", req_ready, 0);
    chk("rst.q", resp_quot, 0);
    chk("rst.r", resp_rem, 0);
    chk("rst.id", resp_id, 0);
    chk("rst.err", resp_err, 0);

    // Contention from reset: 0 first, then 1, then strict alternation.
    put(0, 8'd10, 8'd3);
    put(1, 8'd7, 8'd7);
    rst = 1'b0;
    serve("ct0", 2'b01, 1'b1, 1'd0, 8'd3, 8'd1, 1'b0, 8);
    serve("ct1", 2'b10, 1'b1, 1'd1, 8'd1, 8'd0, 1'b0, 4);
    put(0, 8'd6, 8'd3);
    put(1, 8'd6, 8'd3);
    serve("alt0", 2'b01, 1'b0, 1'd0, 8'd2, 8'd0, 1'b0, 6);
    serve("alt1", 2'b10, 1'b0, 1'd1, 8'd2, 8'd0, 1'b0, 6);
    serve("alt2", 2'b01, 1'b0, 1'd0, 8'd2, 8'd0, 1'b0, 6);
    serve("alt3", 2'b10, 1'b0, 1'd1, 8'd2, 8'd0, 1'b0, 6);
    req_valid = '0;

    // Single request and divide-by-zero.
    put(0, 8'd23, 8'd5);
    serve("one", 2'b01, 1'b1, 1'd0, 8'd4, 8'd3, 1'b0, 10);
    put(1, 8'd9, 8'd0);
    serve("dz", 2'b10, 1'b1, 1'd1, 8'hFF, 8'd9, 1'b1, 1);

    // Backpressure in DONE with requester 1 pending.
    put(0, 8'd50, 8'd7);
    #1;
    chk("bp.gnt", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    t = 1;
    while (!resp_valid && t < 600) begin
      @(posedge clk); #1;
      t++;
    end
    chk("bp.lat", t, 16);
    put(1, 8'd9, 8'd2);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp.vld", resp_valid, 1);
      chk("bp.q", resp_quot, 7);
      chk("bp.r", resp_rem, 1);
      chk("bp.busy", busy, 1);
      chk("bp.rdy", req_ready, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("bp.rel.vld", resp_valid, 0);
    chk("bp.rel.busy", busy, 0);
    serve("bp2", 2'b10, 1'b1, 1'd1, 8'd4, 8'd1, 1'b0, 10);

    // Reset during the 20th SUB of 200/1.
    put(0, 8'd200, 8'd1);
    #1;
    chk("mr.gnt", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (39) @(posedge clk);
    #1;
    chk("mr.busy", busy, 1);
    chk("mr.q", resp_quot, 19);
    chk("mr.r", resp_rem, 181);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mr.vld", resp_valid, 0);
    chk("mr.busy0", busy, 0);
    chk("mr.q0", resp_quot, 0);
    chk("mr.r0", resp_rem, 0);
    chk("mr.id0", resp_id, 0);
    chk("mr.err0", resp_err, 0);
    ghost = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (resp_valid) ghost++;
    end
    chk("mr.ghost", ghost, 0);
    put(0, 8'd6, 8'd4);
    serve("mr.new", 2'b01, 1'b1, 1'd0, 8'd1, 8'd2, 1'b0, 4);

    // Edge operands.
    put(0, 8'd0, 8'd5);
    serve("e0", 2'b01, 1'b1, 1'd0, 8'd0, 8'd0, 1'b0, 2);
    put(1, 8'd255, 8'd255);
    serve("eff", 2'b10, 1'b1, 1'd1, 8'd1, 8'd0, 1'b0, 4);
    put(0, 8'd4, 8'd9);
    serve("e49", 2'b01, 1'b1, 1'd0, 8'd0, 8'd4, 1'b0, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/div_share_sequencer.md
Name: div_share_sequencer

Overview:
Sequencer and arbiter for a shared repeated-subtraction divider. Up to NREQ requesters submit dividend/divisor pairs over a valid/ready handshake. A round-robin arbiter grants one requester at a time. An FSM then runs the load → compare → subtract loop over an internal remainder/quotient datapath and returns quotient, remainder, error flag and requester ID over a valid/ready response port. It sits between the operand producers and result consumers and replaces the fixed single-user control path.

Parameters:
NREQ, 2, number of requesters (2..8)
W, 8, operand/result width in bits
IDW, $clog2(NREQ) (minimum 1), width of requester ID

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept; one-hot or zero
req_dividend  in  NREQ*W  packed dividends; requester i at [i*W +: W]
req_divisor  in  NREQ*W  packed divisors; same packing
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts result
resp_id  out  IDW  index of the requester that owns the result
resp_quot  out  W  quotient
resp_rem  out  W  remainder
resp_err  out  1  divide-by-zero flag
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=1 at a clock edge, in any state, including mid-division):
  - state←IDLE; req_ready=0; resp_valid=0; resp_id=0; resp_quot=0; resp_rem=0; resp_err=0; busy=0.
  - Internal regs: rem, quot and div cleared to 0; round-robin pointer last←NREQ-1, so requester 0 has top priority first.
  - Any in-flight operation is discarded and no response is issued.
- FSM states: IDLE, CMP, SUB, DONE.
- IDLE:
  - If any req_valid is high, the winner is the first requester set at index last+1, last+2, … (mod NREQ).
  - req_ready[winner]=1 combinationally in this cycle only; the handshake completes at the edge.
  - At that edge: rem←dividend, div←divisor, quot←0, id←winner, last←winner.
  - Next state is CMP, or DONE with err=1 if divisor==0.
  - No request is accepted in any state other than IDLE.
- CMP:
  - If rem>=div (unsigned), next state is SUB.
  - Otherwise next state is DONE with err=0.
- SUB:
  - rem←rem−div; quot←quot+1 (W-bit; cannot overflow because div≥1); next state is CMP.
- DONE:
  - resp_valid=1, with resp_id/quot/rem/err driven from registers and held stable until resp_ready=1.
  - On resp_ready=1 the next state is IDLE. resp_valid drops the following cycle.
- Divide-by-zero: resp_err=1, resp_quot={W{1}}, resp_rem=dividend.
- Latency: accept edge to resp_valid high = 2·Q+2 cycles for quotient Q (Q CMP/SUB pairs plus a final CMP). Divide-by-zero takes 1 cycle.
- Back-to-back: earliest next accept is the cycle after the DONE handshake. No request overlaps a response.
- Requester behaviour while pending: a requester held low on req_ready must keep req_valid and its operands stable. The arbiter re-evaluates every IDLE cycle.
- Simultaneous requests: strict rotation; a requester cannot be granted twice while another valid requester waits.
- Dividend 0: one CMP cycle, then quot=0, rem=0.

Decomposition:
- Shared package div_pkg holds:
  - state encoding localparams: IDLE=2'd0, CMP=2'd1, SUB=2'd2, DONE=2'd3;
  - the default W;
  - the zero-divisor quotient constant.
- One sub-module, rr_arbiter (parameter NREQ), is natural. Inputs: req vector, last pointer, enable. Outputs: one-hot grant and encoded index.
- The FSM, datapath registers and response port stay in div_share_sequencer.

Test Plan:
- Single request: requester 0 sends 23/5 → resp_quot=4, resp_rem=3, resp_err=0, resp_id=0; resp_valid rises exactly 10 cycles after the accept edge.
- Divide-by-zero: requester 1 sends 9/0 → 1 cycle later resp_err=1, resp_quot=8'hFF, resp_rem=9, resp_id=1.
- Contention: both requesters valid from reset with 10/3 and 7/7 → grant order 0, then 1. Results are 3r1 with id 0, then 1r0 with id 1. Then hold both valid and confirm strict alternation 0,1,0,1.
- Backpressure: hold resp_ready=0 for 5 cycles in DONE → outputs stay stable, busy=1, req_ready stays 0 despite pending req_valid. Release it → IDLE next cycle.
- Reset mid-operation: 200/1, assert rst during the 20th SUB → all outputs are 0 next cycle and no response is issued. A new 6/4 request then yields 1r2.
- Edge operands: 0/5 → 0r0 after 2 cycles; 255/255 → 1r0; 4/9 → 0r4.
